// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: handshake front end for a sequential shift-add multiplier,
// feeding it operand magnitudes and sign-correcting the captured product.
module mult_issue_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 70
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_result,
  output logic                 out_ovf,
  output logic                 busy,
  output logic                 mult_rst,
  output logic [WIDTH-1:0]     mult_a,
  output logic [WIDTH-1:0]     mult_b,
  input  logic [2*WIDTH-1:0]   mult_res
);
  localparam int CW = $clog2(MULT_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mag_a_q, mag_a_d, mag_b_q, mag_b_d;
  logic neg_q, neg_d, sgn_q, sgn_d, ovf_q, ovf_d;
  logic [2*WIDTH-1:0] res_q, res_d, prod;
  logic accept, last, prod_ovf;
  assign in_ready   = (state_q == IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign last       = cnt_q == CW'(MULT_CYCLES - 1);
  assign prod       = neg_q ? ~mult_res + 1'b1 : mult_res;
  // Overflow means the upper half is not the extension of the lower half's top bit.
  assign prod_ovf   = sgn_q ? (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}})
                            : (|prod[2*WIDTH-1:WIDTH]);
  assign out_valid  = state_q == DONE;
  assign busy       = state_q != IDLE;
  assign mult_rst   = rst | (state_q == START);
  assign mult_a     = mag_a_q;
  assign mult_b     = mag_b_q;
  assign out_result = res_q;
  assign out_ovf    = ovf_q;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_d   = neg_q;
    sgn_d   = sgn_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: if (accept) begin
        state_d = START;
        mag_a_d = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a;
        mag_b_d = (in_signed && in_b[WIDTH-1]) ? -in_b : in_b;
        neg_d   = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
        sgn_d   = in_signed;
      end
      START: begin
        state_d = RUN;
        cnt_d   = '0;
      end
      RUN: begin
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          state_d = DONE;
          res_d   = prod;
          ovf_d   = prod_ovf;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_q   <= 1'b0;
      sgn_q   <= 1'b0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_q   <= neg_d;
      sgn_q   <= sgn_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
    end
  end
endmodule

// File: doc/mult_issue_ctrl.md
# mult_issue_ctrl

Operand-issue and result-capture controller that sits directly in front of the 32-bit sequential shift-add multiplier in the ALU datapath. It accepts a multiply request through a valid/ready handshake and latches the operands. It converts signed operands to magnitudes, starts the multiplier with a one-cycle start pulse on the multiplier's reset input, and counts a fixed number of cycles to completion. It then sign-corrects the 64-bit product and holds it on an output valid/ready handshake until the consumer takes it.

## Interface
- WIDTH, 32, operand width; product is 2*WIDTH
- MULT_CYCLES, 70, clock cycles from the end of the start pulse until the multiplier's result is valid and stable
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  request present
- in_ready  output  1  controller can accept a request
- in_a  input  WIDTH  multiplicand
- in_b  input  WIDTH  multiplier
- in_signed  input  1  1 = two's-complement operands; 0 = unsigned
- out_valid  output  1  out_result is valid
- out_ready  input  1  consumer takes the result
- out_result  output  2*WIDTH  sign-corrected product
- out_ovf  output  1  upper WIDTH bits of out_result are not the extension of bit WIDTH-1 (sign extension if signed, zero if unsigned)
- busy  output  1  state is not IDLE
- mult_rst  output  1  start/reset to the multiplier
- mult_a  output  WIDTH  magnitude operand A to the multiplier
- mult_b  output  WIDTH  magnitude operand B to the multiplier
- mult_res  input  2*WIDTH  raw unsigned product from the multiplier

## Operation
- There is one clock domain. Reset is synchronous and active-high. All state updates on the rising edge of clk.
- States and transitions:
  - IDLE -> START when in_valid && in_ready.
  - START -> RUN after exactly 1 cycle.
  - RUN -> DONE when cnt == MULT_CYCLES-1.
  - DONE -> IDLE when out_ready.
- On accept, the controller latches:
  - mag_a = (in_signed && in_a[WIDTH-1]) ? -in_a : in_a, as a WIDTH-bit unsigned value. 0x8000_0000 maps to 0x8000_0000, which is correct as unsigned 2^31.
  - mag_b by the same rule.
  - neg = in_signed && (in_a[WIDTH-1] ^ in_b[WIDTH-1]).
  - sgn = in_signed.
- mult_a and mult_b are driven from the latched magnitudes. They are stable from the cycle after accept until the controller leaves DONE.
- mult_rst = rst | (state == START). The multiplier is therefore held in reset during a system reset and receives exactly one start cycle per request.
- RUN uses a counter cnt, cleared on entry to RUN and incremented each RUN cycle.
- On the RUN -> DONE edge:
  - out_result <= neg ? (~mult_res + 1) : mult_res, computed modulo 2^(2*WIDTH).
  - out_ovf is computed from the new out_result.
- in_ready = (state == IDLE) && !rst.
- out_valid = (state == DONE).
- out_result and out_ovf stay unchanged until the next capture.
- A new request is never accepted in the same cycle a result is handed off. in_ready first rises in the cycle after the out handshake.
- in_valid during START, RUN or DONE is ignored. The upstream source must hold the request until in_ready is high.

## Timing
- Reset values: state IDLE, cnt 0, out_valid 0, out_result 0, out_ovf 0, busy 0, mult_a 0, mult_b 0. in_ready and mult_rst follow from these while rst is high: mult_rst = 1 and in_ready = 0.
- Accept in cycle T:
  - START (mult_rst = 1) in cycle T+1.
  - RUN in cycles T+2 .. T+1+MULT_CYCLES.
  - out_valid rises in cycle T+2+MULT_CYCLES.
  - Latency from accept to out_valid is MULT_CYCLES+2 cycles.
- Handoff in cycle U (out_valid && out_ready): out_valid = 0 and in_ready = 1 in cycle U+1.
- Back-to-back throughput is one result per MULT_CYCLES+3 cycles when out_ready is held at 1.
- Reset mid-operation (START, RUN or DONE):
  - The request in progress is discarded and the controller enters IDLE on the next edge, with all outputs at their reset values.
  - No partial result is ever presented.
- rst has priority over every other input in the same cycle.
- Zero operands: normal latency. Result 0, out_ovf 0, and neg has no effect because -0 = 0.

## Test plan
- Unsigned 35 × 190, out_ready held 1 → out_valid exactly MULT_CYCLES+2 cycles after accept, out_result = 6650, out_ovf = 0. Then 57 × 813 → 46341. Then 111 × 20 → 2220.
- Signed -7 × 6 → out_result = 0xFFFF_FFFF_FFFF_FFD6 (-42), out_ovf = 0. Signed -7 × -6 → 42.
- Signed 0x8000_0000 × 0x8000_0000 → 0x4000_0000_0000_0000, out_ovf = 1. Unsigned 0xFFFF_FFFF × 0xFFFF_FFFF → 0xFFFF_FFFE_0000_0001, out_ovf = 1.
- Backpressure: hold out_ready = 0 for 10 cycles after out_valid → out_result stable and in_ready = 0 throughout. A second request held on in_valid is accepted only in the cycle after out_ready rises.
- Reset in the middle of RUN (cnt = 30) → next cycle: state IDLE, out_valid = 0, out_result = 0, mult_rst = 1 while rst is high. A following request 3 × 4 completes normally with result 12.
- mult_rst checks:
  - mult_rst is high for exactly one cycle per request outside reset.
  - mult_a and mult_b do not change during RUN, even when in_a and in_b are toggled.
